// File: rtl/alu_pkg.sv
// Purpose: shared op codes, FSM state type and op-legality decode for alu_seq.
// Latency: n/a (declarations and a combinational helper only).
// Backpressure: n/a. MULTU is legal only when ALU_MUL_EN is defined.
package alu_pkg;

  localparam logic [5:0] OP_ADD   = 6'b100000;
  localparam logic [5:0] OP_SUB   = 6'b100010;
  localparam logic [5:0] OP_AND   = 6'b100100;
  localparam logic [5:0] OP_OR    = 6'b100101;
  localparam logic [5:0] OP_XOR   = 6'b100110;
  localparam logic [5:0] OP_NOR   = 6'b100111;
  localparam logic [5:0] OP_SLT   = 6'b101010;
  localparam logic [5:0] OP_SLTU  = 6'b101011;
  localparam logic [5:0] OP_SLL   = 6'b000000;
  localparam logic [5:0] OP_SRL   = 6'b000010;
  localparam logic [5:0] OP_SRA   = 6'b000011;
  localparam logic [5:0] OP_MULTU = 6'b011001;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL      = 2'd1,
    ST_MUL_WAIT = 2'd2
  } state_e;

  // True for every funct code this build executes.
  function automatic logic is_legal(input logic [5:0] op);
    logic ok;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR,
      OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_SRA: ok = 1'b1;
`ifdef ALU_MUL_EN
      OP_MULTU: ok = 1'b1;
`endif
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Purpose: iterative W x W unsigned shift-add multiplier with start/done/ack.
// Latency: W cycles after the start edge; done then holds until ack.
// Backpressure: product and done stay stable until ack; start restarts at once.
module alu_mul_seq #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           ack,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] prod
);

  localparam int CW = $clog2(W + 1);

  logic           busy_q,   busy_d;
  logic [CW-1:0]  cnt_q,    cnt_d;
  logic [2*W-1:0] acc_q,    acc_d;
  logic [2*W-1:0] mcand_q,  mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;

  assign done = busy_q && (cnt_q == '0);
  assign prod = acc_q;

  // One partial product per cycle: add the shifted multiplicand when the current multiplier LSB is set.
  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (start) begin
      busy_d   = 1'b1;
      cnt_d    = CW'(W);
      acc_d    = '0;
      mcand_d  = {{W{1'b0}}, a};
      mplier_d = b;
    end else if (busy_q && (cnt_q != '0)) begin
      acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
    end else if (done && ack) begin
      busy_d   = 1'b0;
    end
  end

  // Iteration state; reset aborts any product in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Purpose: registered MIPS-funct ALU; iterative MULTU present only when ALU_MUL_EN is defined.
// Latency: 1 cycle for single-cycle ops, W+1 cycles for MULTU (accept to out_valid).
// Backpressure: output register holds while out_valid && !out_ready; in_ready drops until it can load.
module alu_seq #(
  parameter int W   = 8,
  parameter int OPW = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [OPW-1:0] op,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   rdo,
  output logic [W-1:0]   rdo_hi,
  output logic           carry,
  output logic           zero,
  output logic           ovf,
  output logic           err
);

  import alu_pkg::*;

  localparam logic [W-1:0] W_V = W'(W);

  logic [5:0]   op6;
  logic         legal;
  logic         accept;
  logic         free;
  logic         is_mul;
  logic         load_single;
  logic         load_mul;
  logic [2*W-1:0] mul_prod;

  logic [W:0]   sum;
  logic [W-1:0] diff;
  logic [W-1:0] sra_v;
  logic         big_sh;
  logic [W-1:0] res_rdo;
  logic         res_carry;
  logic         res_ovf;
  logic         res_err;

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] rdo_q,       rdo_d;
  logic         carry_q,     carry_d;
  logic         zero_q,      zero_d;
  logic         ovf_q,       ovf_d;
  logic         err_q,       err_d;

  // Funct bits above [5:0] must be zero for the op to be legal.
  assign op6    = op[5:0];
  assign legal  = ((op >> 6) == '0) && is_legal(op6);
  assign free   = !out_valid_q || out_ready;
  assign accept = in_valid && in_ready;
  assign load_single = accept && !is_mul;

  assign sum    = {1'b0, a} + {1'b0, b};
  assign diff   = a - b;
  assign sra_v  = $signed(a) >>> b;
  assign big_sh = (b >= W_V);

  // Single-cycle datapath; MULTU results come from the multiplier instead.
  always_comb begin
    res_rdo   = '0;
    res_carry = 1'b0;
    res_ovf   = 1'b0;
    res_err   = 1'b0;
    if (!legal) begin
      res_err = 1'b1;
    end else begin
      case (op6)
        OP_ADD: begin
          res_rdo   = sum[W-1:0];
          res_carry = sum[W];
          res_ovf   = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
        end
        OP_SUB: begin
          res_rdo   = diff;
          res_carry = (a < b);
          res_ovf   = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
        end
        OP_AND:  res_rdo = a & b;
        OP_OR:   res_rdo = a | b;
        OP_XOR:  res_rdo = a ^ b;
        OP_NOR:  res_rdo = ~(a | b);
        OP_SLT:  res_rdo = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
        OP_SLTU: res_rdo = {{(W-1){1'b0}}, (a < b)};
        OP_SLL:  res_rdo = big_sh ? '0 : (a << b);
        OP_SRL:  res_rdo = big_sh ? '0 : (a >> b);
        OP_SRA:  res_rdo = big_sh ? {W{a[W-1]}} : sra_v;
        default: res_rdo = '0;
      endcase
    end
  end

`ifdef ALU_MUL_EN
  state_e       state_q, state_d;
  logic         mul_start;
  logic         mul_done;
  logic [W-1:0] rdo_hi_q, rdo_hi_d;

  assign is_mul    = legal && (op6 == OP_MULTU);
  assign mul_start = accept && is_mul;

  alu_mul_seq #(.W(W)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .ack   (load_mul),
    .a     (a),
    .b     (b),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: park in MUL_WAIT when the product is ready but the output register is occupied.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (mul_start) state_d = ST_MUL;
      ST_MUL:      if (mul_done)  state_d = free ? ST_IDLE : ST_MUL_WAIT;
      ST_MUL_WAIT: if (free)      state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: accept only in IDLE with room; load the product on the exit from MUL/MUL_WAIT.
  always_comb begin
    in_ready = (state_q == ST_IDLE) && free;
    load_mul = ((state_q == ST_MUL) && mul_done && free) ||
               ((state_q == ST_MUL_WAIT) && free);
  end

  // High half of the product; zero for every other result.
  always_comb begin
    rdo_hi_d = rdo_hi_q;
    if (load_single)   rdo_hi_d = '0;
    else if (load_mul) rdo_hi_d = mul_prod[2*W-1:W];
  end

  // High-half output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdo_hi_q <= '0;
    else        rdo_hi_q <= rdo_hi_d;
  end

  assign rdo_hi = rdo_hi_q;
`else
  assign is_mul   = 1'b0;
  assign load_mul = 1'b0;
  assign mul_prod = '0;
  assign in_ready = free;
  assign rdo_hi   = '0;
`endif

  // Output register: load a new result, retire on out_ready, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q && !out_ready;
    rdo_d       = rdo_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
    if (load_single) begin
      out_valid_d = 1'b1;
      rdo_d       = res_rdo;
      carry_d     = res_carry;
      zero_d      = !res_err && (res_rdo == '0);
      ovf_d       = res_ovf;
      err_d       = res_err;
    end else if (load_mul) begin
      out_valid_d = 1'b1;
      rdo_d       = mul_prod[W-1:0];
      carry_d     = 1'b0;
      zero_d      = (mul_prod == '0);
      ovf_d       = 1'b0;
      err_d       = 1'b0;
    end
  end

  // Result and flag flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      rdo_q       <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      rdo_q       <= rdo_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign rdo       = rdo_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Purpose: self-checking bench for alu_seq (W=8) against an arithmetic reference model.
// Latency: checks 1-cycle results and W+1-cycle MULTU (when ALU_MUL_EN is defined).
// Backpressure: exercises held results, queued accept on out_ready, and reset mid-MULTU.
module tb_alu_seq;

  localparam int W   = 8;
  localparam int OPW = 6;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [OPW-1:0] op;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   rdo;
  logic [W-1:0]   rdo_hi;
  logic           carry;
  logic           zero;
  logic           ovf;
  logic           err;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] rdo;
    logic [7:0] hi;
    logic       carry;
    logic       zero;
    logic       ovf;
    logic       err;
  } exp_t;

  alu_seq #(.W(W), .OPW(OPW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rdo       (rdo),
    .rdo_hi    (rdo_hi),
    .carry     (carry),
    .zero      (zero),
    .ovf       (ovf),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Reference model: results from plain integer arithmetic on the operand values.
  function automatic exp_t model(input int va, input int vb, input int vop);
    exp_t e;
    int   sa, sb, r, sh;
    bit   is_mul;
    e = '{rdo: 8'd0, hi: 8'd0, carry: 1'b0, zero: 1'b0, ovf: 1'b0, err: 1'b0};
    sa = (va >= 128) ? va - 256 : va;
    sb = (vb >= 128) ? vb - 256 : vb;
    sh = (vb > 7) ? 7 : vb;
    r = 0;
    is_mul = 1'b0;
    case (vop)
      32: begin r = va + vb; e.carry = (r > 255); e.ovf = ((sa + sb) > 127) || ((sa + sb) < -128); end
      34: begin r = va - vb; e.carry = (va < vb); e.ovf = ((sa - sb) > 127) || ((sa - sb) < -128); end
      36: r = va & vb;
      37: r = va | vb;
      38: r = va ^ vb;
      39: r = 255 - (va | vb);
      42: r = (sa < sb) ? 1 : 0;
      43: r = (va < vb) ? 1 : 0;
      0:  r = (vb >= 8) ? 0 : (va * (1 << vb));
      2:  r = (vb >= 8) ? 0 : (va / (1 << vb));
      3:  r = sa >>> sh;
`ifdef ALU_MUL_EN
      25: begin r = va * vb; is_mul = 1'b1; end
`endif
      default: e.err = 1'b1;
    endcase
    if (!e.err) begin
      e.rdo = 8'(r & 255);
      if (is_mul) begin
        e.hi   = 8'((r >> 8) & 255);
        e.zero = (r == 0);
      end else begin
        e.zero = ((r & 255) == 0);
      end
    end
    return e;
  endfunction

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, expv);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int expv);
    n_cmp++;
    assert (obs == expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic chk_res(input string tag, input exp_t e);
    chk1({tag, ".vld"},   out_valid, 1'b1);
    chk8({tag, ".rdo"},   rdo,       e.rdo);
    chk8({tag, ".hi"},    rdo_hi,    e.hi);
    chk1({tag, ".carry"}, carry,     e.carry);
    chk1({tag, ".zero"},  zero,      e.zero);
    chk1({tag, ".ovf"},   ovf,       e.ovf);
    chk1({tag, ".err"},   err,       e.err);
  endtask

  // Issue one op with out_ready=1, scramble inputs after accept, then check latency and result.
  task automatic issue(input int va, input int vb, input int vop, input string tag);
    exp_t e;
    int   w, lat, exp_lat;
    e = model(va, vb, vop);
    exp_lat = (vop == 25 && !e.err) ? W + 1 : 1;
    @(negedge clk);
    a = 8'(va); b = 8'(vb); op = 6'(vop); in_valid = 1'b1;
    #1;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk); #1; w++;
    end
    chk1({tag, ".in_rdy"}, in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); op = 6'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      chk1({tag, ".busy_rdy"}, in_ready, 1'b0);
      @(negedge clk); lat++;
    end
    chki({tag, ".lat"}, lat, exp_lat);
    chk_res(tag, e);
  endtask

  int   legal_ops[12] = '{32, 34, 36, 37, 38, 39, 42, 43, 0, 2, 3, 25};
  int   single_ops[11] = '{32, 34, 36, 37, 38, 39, 42, 43, 0, 2, 3};
  exp_t q[$];

  initial begin
    int   ra, rb, rop;
    exp_t e;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk1("rst.vld",   out_valid, 1'b0);
    chk8("rst.rdo",   rdo,       8'h00);
    chk8("rst.hi",    rdo_hi,    8'h00);
    chk1("rst.carry", carry,     1'b0);
    chk1("rst.zero",  zero,      1'b0);
    chk1("rst.ovf",   ovf,       1'b0);
    chk1("rst.err",   err,       1'b0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk1("rst.in_rdy", in_ready, 1'b1);

    // Directed cases.
    issue(250, 20, 32, "add_carry");
    chk8("add_carry.const", rdo, 8'd14);
    issue(250, 250, 34, "sub_zero");
    issue(20, 250, 34, "sub_borrow");
    chk8("sub_borrow.const", rdo, 8'd26);
    issue(8'h7F, 8'hFF, 34, "sub_ovf");
    chk1("sub_ovf.const", ovf, 1'b1);
    issue(8'hC0, 3, 3, "sra3");
    chk8("sra3.const", rdo, 8'hF8);
    issue(8'hC0, 3, 2, "srl3");
    issue(8'hC0, 9, 3, "sra9");
    chk8("sra9.const", rdo, 8'hFF);
    issue(8'h01, 8, 0, "sll8");
    issue(8'h80, 8'h01, 42, "slt");
    issue(8'h80, 8'h01, 43, "sltu");
    issue(8'h05, 8'h07, 17, "illegal");
    issue(200, 150, 25, "multu");
`ifdef ALU_MUL_EN
    chk8("multu.const_lo", rdo, 8'h30);
    chk8("multu.const_hi", rdo_hi, 8'h75);
`else
    chk1("multu.const_err", err, 1'b1);
`endif

    // Backpressure: hold AND result, queue XOR, release.
    @(negedge clk);
    out_ready = 1'b0;
    a = 8'hAA; b = 8'hF0; op = 6'd36; in_valid = 1'b1;
    #1;
    chk1("bp.first_rdy", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    op = 6'd38;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk1("bp.hold_vld", out_valid, 1'b1);
      chk8("bp.hold_rdo", rdo, 8'hA0);
      chk1("bp.hold_rdy", in_ready, 1'b0);
      @(negedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    chk1("bp.release_rdy", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk1("bp.xor_vld", out_valid, 1'b1);
    chk8("bp.xor_rdo", rdo, 8'h5A);

    // Back-to-back single-cycle ops with out_ready=1: one result per cycle, no bubbles.
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) begin
        e = q.pop_front();
        chk_res("stream", e);
      end
      chk1("stream.rdy", in_ready, 1'b1);
      ra = int'($urandom_range(0, 255));
      rb = (i % 2 == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 10));
      rop = single_ops[$urandom_range(0, 10)];
      a = 8'(ra); b = 8'(rb); op = 6'(rop); in_valid = 1'b1;
      q.push_back(model(ra, rb, rop));
      @(negedge clk);
    end
    in_valid = 1'b0;
    e = q.pop_front();
    chk_res("stream.last", e);

    // Randomized ops including illegal codes.
    for (int i = 0; i < 120; i++) begin
      ra = int'($urandom_range(0, 255));
      rb = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 10));
      if ($urandom_range(0, 4) == 0) rop = int'($urandom_range(0, 63));
      else                           rop = legal_ops[$urandom_range(0, 11)];
      issue(ra, rb, rop, "rand");
    end

    // Reset four cycles into MULTU, with the output side stalled.
    @(negedge clk);
    out_ready = 1'b0;
    a = 8'd200; b = 8'd150; op = 6'd25; in_valid = 1'b1;
    #1;
    chk1("rmul.rdy", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk1("rmul.vld", out_valid, 1'b0);
    chk8("rmul.rdo", rdo,       8'h00);
    chk8("rmul.hi",  rdo_hi,    8'h00);
    chk1("rmul.err", err,       1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk); #1;
    chk1("rmul.post_rdy", in_ready, 1'b1);
    for (int i = 0; i < 12; i++) begin
      chk1("rmul.no_stale", out_valid, 1'b0);
      @(negedge clk);
    end
    issue(1, 1, 32, "post_rst_add");
    chk8("post_rst_add.const", rdo, 8'd2);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, observed no end, expected summary");
    $fatal(1, "watchdog");
  end

endmodule
